adder_tree_sequencer: RTL and testbench
=======================================

// Module: adder_tree_sequencer
// PURPOSE
//  Streams multi-beat reduction jobs through one shared combinational balanced adder tree.
//  Accepts beats of 2**EXPONENT lanes over valid/ready and registers each beat onto the tree inputs.
//  Accumulates the tree sum of every beat and returns one ACC_WIDTH result per job.
//  Sits between the operand stream producer and the result consumer; the tree is instantiated outside this block.
// PARAMETERS
//  EXPONENT    4   tree has 2**EXPONENT lanes
//  DATA_WIDTH  4   lane width and tree output width
//  ACC_WIDTH   16  accumulator/result width (>= DATA_WIDTH)
//  CNT_WIDTH   8   width of the job beat count
// PORTS
//  clk           in   1                       single clock, rising edge
//  rst_n         in   1                       asynchronous active-low reset
//  start_i       in   1                       job start request; sampled in IDLE only
//  beats_i       in   CNT_WIDTH               beats in job; sampled with start_i
//  busy_o        out  1                       high in any state other than IDLE
//  in_valid_i    in   1                       beat valid
//  in_ready_o    out  1                       beat ready
//  in_data_i     in   2**EXPONENT*DATA_WIDTH  beat lanes; lane k = bits [k*DATA_WIDTH +: DATA_WIDTH]
//  tree_in_o     out  2**EXPONENT*DATA_WIDTH  registered lanes driven to the tree
//  tree_sum_i    in   DATA_WIDTH              combinational tree result for tree_in_o
//  res_valid_o   out  1                       result valid
//  res_ready_i   in   1                       result ready
//  res_data_o    out  ACC_WIDTH               job sum
//  sat_o         out  1                       sticky saturation flag for current job
// BEHAVIOUR
//  Reset (async assert, sync deassert, any state):
//   - state=IDLE; all outputs 0; tree_in_o, acc, count and tree_vld cleared.
//   - a job in flight is discarded and never reported.
//  States:
//   - IDLE: in_ready_o=0. On start_i: acc<=0, sat<=0, count<=beats_i.
//     Go to DONE if beats_i==0, otherwise RUN.
//   - RUN: in_ready_o=1. On handshake (in_valid_i&in_ready_o): tree_in_o<=in_data_i, tree_vld<=1, count<=count-1.
//     If count==1 at the handshake, go to DRAIN. With no handshake, tree_vld<=0 and tree_in_o holds.
//   - DRAIN: in_ready_o=0. Single cycle, then DONE.
//   - DONE: res_valid_o=1, res_data_o=acc; both held stable until res_ready_i. On res_ready_i go to IDLE.
//  Accumulate: every cycle with tree_vld=1, acc <= acc + zero-extended tree_sum_i.
//   The add happens in RUN or DRAIN, the cycle after each handshake.
//  Width rules:
//   - the tree sum is modulo 2**DATA_WIDTH (the tree truncates); this block does not widen it.
//   - acc overflow handling per CONFIGURATION.
//  Throughput/latency:
//   - one beat per cycle sustained in RUN.
//   - res_valid_o rises 2 cycles after the last beat handshake.
//   - zero-beat job: res_valid_o one cycle after start_i, result 0.
//  start_i outside IDLE is ignored (no queueing). in_valid_i outside RUN is not accepted.
//  Back-to-back jobs: start_i may be high in the cycle after the result handshake (IDLE).
//  res_ready_i held high in DONE gives a one-cycle result pulse.
// CONFIGURATION
//  ADDER_TREE_SEQ_SATURATE_EN defined:
//   - if acc + sum > 2**ACC_WIDTH-1, acc <= 2**ACC_WIDTH-1 and sat<=1.
//   - sat is sticky until the next start; sat_o=sat.
//  Not defined: acc wraps modulo 2**ACC_WIDTH; sat_o tied 0.
// TESTING (EXPONENT=2, DATA_WIDTH=8, ACC_WIDTH=10, CNT_WIDTH=8)
//  1. start, beats=3, three back-to-back beats of lanes {10,20,30,40} -> res_data_o=300, res_valid_o 2 cycles after 3rd beat.
//  2. beats=0 -> res_valid_o next cycle, res_data_o=0, in_ready_o never 1.
//  3. beats=2, lanes {255,1,0,0} then {5,5,5,5} -> tree sum 0 then 20; res_data_o=20 (tree wrap honoured).
//  4. 11 beats of {25,25,25,25} -> undefined macro: res_data_o=76, sat_o=0; defined: res_data_o=1023, sat_o=1.
//  5. beats=4, in_valid_i gapped 1-on/2-off, res_ready_i low 5 cycles in DONE -> sum correct, res_data_o stable while stalled, start_i ignored while busy.
//  6. rst_n low mid-RUN after 2 of 4 beats -> all outputs 0 immediately; new job of 1 beat {1,2,3,4} -> res_data_o=10.

Source files
------------

// File: rtl/adder_tree_sequencer.sv
// Sequences multi-beat reduction jobs through an external balanced adder tree and accumulates one result per job.
// Optional saturating accumulator: define ADDER_TREE_SEQ_SATURATE_EN (default build wraps modulo 2**ACC_WIDTH).
module adder_tree_sequencer #(
  parameter int unsigned EXPONENT   = 4,
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned ACC_WIDTH  = 16,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start_i,
  input  logic [CNT_WIDTH-1:0]                 beats_i,
  output logic                                 busy_o,
  input  logic                                 in_valid_i,
  output logic                                 in_ready_o,
  input  logic [(2**EXPONENT)*DATA_WIDTH-1:0]  in_data_i,
  output logic [(2**EXPONENT)*DATA_WIDTH-1:0]  tree_in_o,
  input  logic [DATA_WIDTH-1:0]                tree_sum_i,
  output logic                                 res_valid_o,
  input  logic                                 res_ready_i,
  output logic [ACC_WIDTH-1:0]                 res_data_o,
  output logic                                 sat_o
);

  localparam int unsigned LANES   = 2**EXPONENT;
  localparam int unsigned TREE_W  = LANES*DATA_WIDTH;
  localparam int unsigned ACC_EXT = ACC_WIDTH+1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d, acc_upd;
  logic                  tree_vld_q, tree_vld_d;
  logic [TREE_W-1:0]     tree_in_q, tree_in_d;
  logic                  busy_q, busy_d;
  logic                  in_ready_q, in_ready_d;
  logic                  res_valid_q, res_valid_d;
  logic [ACC_WIDTH-1:0]  res_data_q, res_data_d;
  logic                  in_hs;
  logic                  job_start;

  assign in_hs     = in_valid_i & in_ready_q;
  assign job_start = (state_q == ST_IDLE) & start_i;

`ifdef ADDER_TREE_SEQ_SATURATE_EN
  // Saturating accumulate: one extra bit detects overflow past 2**ACC_WIDTH-1.
  logic [ACC_WIDTH:0] acc_wide;
  logic               sat_q, sat_d, sat_upd;

  always_comb begin
    acc_wide = {1'b0, acc_q} + ACC_EXT'(tree_sum_i);
    acc_upd  = acc_q;
    sat_upd  = sat_q;
    if (tree_vld_q) begin
      if (acc_wide[ACC_WIDTH]) begin
        acc_upd = '1;
        sat_upd = 1'b1;
      end else begin
        acc_upd = acc_wide[ACC_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    sat_d = sat_upd;
    if (job_start) begin
      sat_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
    end
  end

  assign sat_o = sat_q;
`else
  // Wrapping accumulate of the zero-extended tree sum.
  always_comb begin
    acc_upd = acc_q;
    if (tree_vld_q) begin
      acc_upd = acc_q + ACC_WIDTH'(tree_sum_i);
    end
  end

  assign sat_o = 1'b0;
`endif

  // Next-state and next-output logic; outputs are registered from the next state.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    acc_d      = acc_upd;
    tree_in_d  = tree_in_q;
    tree_vld_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          acc_d   = '0;
          count_d = beats_i;
          state_d = (beats_i == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (in_hs) begin
          tree_in_d  = in_data_i;
          tree_vld_d = 1'b1;
          count_d    = count_q - CNT_WIDTH'(1);
          if (count_q == CNT_WIDTH'(1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (res_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d      = (state_d != ST_IDLE);
    in_ready_d  = (state_d == ST_RUN);
    res_valid_d = (state_d == ST_DONE);
    res_data_d  = (state_d == ST_DONE) ? acc_d : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      acc_q       <= '0;
      tree_vld_q  <= 1'b0;
      tree_in_q   <= '0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      tree_vld_q  <= tree_vld_d;
      tree_in_q   <= tree_in_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  assign busy_o      = busy_q;
  assign in_ready_o  = in_ready_q;
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;
  assign tree_in_o   = tree_in_q;

endmodule

// File: tb/tb_adder_tree_sequencer.sv
// Directed, table-driven bench for adder_tree_sequencer with a behavioural 4-lane adder tree.
module tb_adder_tree_sequencer;

  localparam int unsigned E  = 2;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 10;
  localparam int unsigned CW = 8;
  localparam int unsigned LW = (2**E)*DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_i;
  logic [CW-1:0] beats_i;
  logic          busy_o;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [LW-1:0] in_data_i;
  logic [LW-1:0] tree_in_o;
  logic [DW-1:0] tree_sum_i;
  logic          res_valid_o;
  logic          res_ready_i;
  logic [AW-1:0] res_data_o;
  logic          sat_o;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    int unsigned       nbeats;
    logic [3:0][31:0]  beat;
    int unsigned       gap;
    int unsigned       stall;
    logic [AW-1:0]     exp_res;
    logic              exp_sat;
  } vec_t;

  vec_t vecs [6];

  adder_tree_sequencer #(
    .EXPONENT  (E),
    .DATA_WIDTH(DW),
    .ACC_WIDTH (AW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .beats_i    (beats_i),
    .busy_o     (busy_o),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_data_i  (in_data_i),
    .tree_in_o  (tree_in_o),
    .tree_sum_i (tree_sum_i),
    .res_valid_o(res_valid_o),
    .res_ready_i(res_ready_i),
    .res_data_o (res_data_o),
    .sat_o      (sat_o)
  );

  always #5 clk = ~clk;

  // External tree: truncating sum of the four registered lanes.
  always_comb begin
    tree_sum_i = 8'(tree_in_o[7:0] + tree_in_o[15:8] + tree_in_o[23:16] + tree_in_o[31:24]);
  end

  function automatic logic [31:0] lanes(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic run_job(input vec_t v, input string tag);
    logic [31:0] d;
    start_i = 1'b1;
    beats_i = CW'(v.nbeats);
    tick();
    start_i = 1'b0;
    check({tag, " busy after start"}, 32'(busy_o), 32'd1);
    if (v.nbeats == 0) begin
      check({tag, " zero job ready low"}, 32'(in_ready_o), 32'd0);
    end else begin
      for (int i = 0; i < int'(v.nbeats); i++) begin
        for (int g = 0; g < int'(v.gap); g++) begin
          in_valid_i = 1'b0;
          start_i    = 1'b1;
          beats_i    = 8'd1;
          tick();
          start_i = 1'b0;
          check({tag, " ready during gap"}, 32'(in_ready_o), 32'd1);
        end
        check({tag, " ready in run"}, 32'(in_ready_o), 32'd1);
        d          = v.beat[(i < 4) ? i : 3];
        in_valid_i = 1'b1;
        in_data_i  = d;
        tick();
        in_valid_i = 1'b0;
        check({tag, " tree_in lanes"}, tree_in_o, d);
      end
      check({tag, " drain ready low"}, 32'(in_ready_o), 32'd0);
      check({tag, " drain valid low"}, 32'(res_valid_o), 32'd0);
      tick();
    end
    check({tag, " res_valid"}, 32'(res_valid_o), 32'd1);
    check({tag, " res_data"}, 32'(res_data_o), 32'(v.exp_res));
    check({tag, " sat"}, 32'(sat_o), 32'(v.exp_sat));
    res_ready_i = 1'b0;
    for (int s = 0; s < int'(v.stall); s++) begin
      start_i = 1'b1;
      beats_i = 8'd0;
      tick();
      check({tag, " stalled valid"}, 32'(res_valid_o), 32'd1);
      check({tag, " stalled data"}, 32'(res_data_o), 32'(v.exp_res));
    end
    start_i     = 1'b0;
    res_ready_i = 1'b1;
    tick();
    res_ready_i = 1'b0;
    check({tag, " valid pulse ends"}, 32'(res_valid_o), 32'd0);
    check({tag, " idle busy"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    vec_t r;
    rst_n       = 1'b0;
    start_i     = 1'b0;
    beats_i     = '0;
    in_valid_i  = 1'b0;
    in_data_i   = '0;
    res_ready_i = 1'b0;

    vecs[0] = '{nbeats: 3, beat: {4{lanes(10, 20, 30, 40)}}, gap: 0, stall: 0,
                exp_res: 10'd300, exp_sat: 1'b0};
    vecs[1] = '{nbeats: 0, beat: '0, gap: 0, stall: 0, exp_res: 10'd0, exp_sat: 1'b0};
    vecs[2] = '{nbeats: 2, beat: {lanes(5, 5, 5, 5), lanes(5, 5, 5, 5), lanes(5, 5, 5, 5), lanes(255, 1, 0, 0)},
                gap: 0, stall: 0, exp_res: 10'd20, exp_sat: 1'b0};
`ifdef ADDER_TREE_SEQ_SATURATE_EN
    vecs[3] = '{nbeats: 11, beat: {4{lanes(25, 25, 25, 25)}}, gap: 0, stall: 0,
                exp_res: 10'd1023, exp_sat: 1'b1};
`else
    vecs[3] = '{nbeats: 11, beat: {4{lanes(25, 25, 25, 25)}}, gap: 0, stall: 0,
                exp_res: 10'd76, exp_sat: 1'b0};
`endif
    // sums 10, 40, 260 mod 256 = 4, 28
    vecs[4] = '{nbeats: 4, beat: {lanes(7, 7, 7, 7), lanes(50, 60, 70, 80), lanes(10, 10, 10, 10), lanes(1, 2, 3, 4)},
                gap: 2, stall: 5, exp_res: 10'd82, exp_sat: 1'b0};
    // 3*255 + 2*129 = 1023, the largest value that does not saturate
    vecs[5] = '{nbeats: 5, beat: {lanes(129, 0, 0, 0), lanes(255, 0, 0, 0), lanes(255, 0, 0, 0), lanes(255, 0, 0, 0)},
                gap: 0, stall: 0, exp_res: 10'd1023, exp_sat: 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 32'(busy_o), 32'd0);
    check("reset ready", 32'(in_ready_o), 32'd0);
    check("reset valid", 32'(res_valid_o), 32'd0);
    check("reset data", 32'(res_data_o), 32'd0);
    check("reset tree_in", tree_in_o, 32'd0);
    rst_n = 1'b1;
    tick();

    for (int k = 0; k < 6; k++) begin
      run_job(vecs[k], $sformatf("vec%0d", k));
    end

    // Asynchronous reset in the middle of a 4-beat job.
    start_i = 1'b1;
    beats_i = 8'd4;
    tick();
    start_i    = 1'b0;
    in_valid_i = 1'b1;
    in_data_i  = lanes(9, 9, 9, 9);
    tick();
    tick();
    in_valid_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrun reset busy", 32'(busy_o), 32'd0);
    check("midrun reset ready", 32'(in_ready_o), 32'd0);
    check("midrun reset valid", 32'(res_valid_o), 32'd0);
    check("midrun reset data", 32'(res_data_o), 32'd0);
    check("midrun reset tree_in", tree_in_o, 32'd0);
    check("midrun reset sat", 32'(sat_o), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("post reset idle", 32'(busy_o), 32'd0);
    r = '{nbeats: 1, beat: {4{lanes(1, 2, 3, 4)}}, gap: 0, stall: 0, exp_res: 10'd10, exp_sat: 1'b0};
    run_job(r, "after_reset");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
